hidden_switch_auth: RTL and testbench

- Authentication front end for the anti-theft chain. It turns raw hidden-switch presses into the qualified `pump_grant` level that the fuel-pump controller consumes on its hidden-switch input.
- Driver must enter a secret press count, with brake held, inside a timed window after ignition-on.
- Wrong or late entries cause a lockout. Repeated failures latch an alarm.

---
 rtl/anti_theft_pkg.sv | 19 +
 rtl/switch_debouncer.sv | 44 ++++
 rtl/hidden_switch_auth.sv | 120 ++++++++++++
 tb/tb_hidden_switch_auth.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anti_theft_pkg.sv
// Shared types and default constants for the anti-theft chain.
// auth_state_t is the authentication FSM state; DEF_* are the production parameter values.
package anti_theft_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    GRANTED = 3'd2,
    LOCKOUT = 3'd3,
    ALARM   = 3'd4
  } auth_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_ENTRY_WINDOW    = 1000;
  localparam int DEF_CODE_PRESSES    = 3;
  localparam int DEF_LOCKOUT_CYCLES  = 500;
  localparam int DEF_MAX_FAILS       = 3;

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus stability-counter debouncer for a mechanical switch.
// rise_pulse is a registered one-cycle strobe on the debounced 0->1 edge.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic [CW-1:0] stable_cnt;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive sample that differs from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
      rise_pulse <= 1'b0;
    end else begin
      sync_1     <= raw;
      sync_2     <= sync_1;
      rise_pulse <= 1'b0;
      if (sync_2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        stable_cnt <= '0;
        level      <= sync_2;
        rise_pulse <= sync_2;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hidden_switch_auth.sv
// Hidden-switch authentication: a secret press count, entered with brake held inside a timed
// window after key-on, raises pump_grant; failed windows lock out and eventually latch an alarm.
module hidden_switch_auth
  import anti_theft_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int ENTRY_WINDOW    = DEF_ENTRY_WINDOW,
  parameter int CODE_PRESSES    = DEF_CODE_PRESSES,
  parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
  parameter int MAX_FAILS       = DEF_MAX_FAILS
) (
  input  logic clk,
  input  logic rst,
  input  logic ignition,
  input  logic brake,
  input  logic hidden_switch_raw,
  output logic pump_grant,
  output logic entry_active,
  output logic locked_out,
  output logic alarm
);

  localparam int TMAX = (ENTRY_WINDOW > LOCKOUT_CYCLES) ? ENTRY_WINDOW : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] WIN_LAST  = TW'(ENTRY_WINDOW - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]    CODE      = 4'(CODE_PRESSES);
  localparam logic [3:0]    PRESS_SAT = 4'(CODE_PRESSES + 1);
  localparam logic [2:0]    FAIL_MAX  = 3'(MAX_FAILS);

  auth_state_t   state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [3:0]    press_cnt, press_n;
  logic [2:0]    fail_cnt, fail_n;
  logic [2:0]    fail_inc;
  logic          press_pulse;

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_switch_db (
    .clk       (clk),
    .rst       (rst),
    .raw       (hidden_switch_raw),
    .rise_pulse(press_pulse)
  );

  assign fail_inc = fail_cnt + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      press_cnt <= '0;
      fail_cnt  <= '0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      press_cnt <= press_n;
      fail_cnt  <= fail_n;
    end
  end

  // The window always runs to full length so the time of the last press is not observable.
  always_comb begin
    state_n = state;
    timer_n = timer;
    press_n = press_cnt;
    fail_n  = fail_cnt;
    case (state)
      IDLE: begin
        if (ignition) begin
          state_n = ENTRY;
          timer_n = '0;
          press_n = '0;
        end
      end
      ENTRY: begin
        if (!ignition) begin
          state_n = IDLE;
        end else if (timer == WIN_LAST) begin
          timer_n = '0;
          if (press_cnt == CODE) begin
            state_n = GRANTED;
            fail_n  = '0;
          end else begin
            fail_n  = fail_inc;
            state_n = (fail_inc == FAIL_MAX) ? ALARM : LOCKOUT;
          end
        end else begin
          timer_n = timer + 1'b1;
          if (press_pulse && brake && (press_cnt != PRESS_SAT)) press_n = press_cnt + 1'b1;
        end
      end
      GRANTED: begin
        if (!ignition) state_n = IDLE;
      end
      LOCKOUT: begin
        if (!ignition) begin
          state_n = IDLE;
        end else if (timer == LOCK_LAST) begin
          state_n = ENTRY;
          timer_n = '0;
          press_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      ALARM: begin
        state_n = ALARM;
      end
      default: state_n = IDLE;
    endcase
  end

  assign pump_grant   = (state == GRANTED);
  assign entry_active = (state == ENTRY);
  assign locked_out   = (state == LOCKOUT);
  assign alarm        = (state == ALARM);

endmodule

// File: tb/tb_hidden_switch_auth.sv
// Self-checking bench for hidden_switch_auth: window outcomes go through an expected queue,
// durations and boundary cycles are checked inline per scenario task.
module tb_hidden_switch_auth;

  localparam logic [3:0] O_IDLE  = 4'b0000;  // {pump_grant, entry_active, locked_out, alarm}
  localparam logic [3:0] O_GRANT = 4'b1000;
  localparam logic [3:0] O_LOCK  = 4'b0010;
  localparam logic [3:0] O_ALARM = 4'b0001;
  localparam int KIND_CLEAN  = 0;
  localparam int KIND_BOUNCY = 1;
  localparam int KIND_GLITCH = 2;

  logic clk = 1'b0;
  logic rst;
  logic ignition;
  logic brake;
  logic hidden_switch_raw;
  logic pump_grant;
  logic entry_active;
  logic locked_out;
  logic alarm;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  int   press_at[8];
  int   press_kind[8];
  logic press_brake[8];
  int   n_press;
  int   ign_drop_at;

  hidden_switch_auth #(
    .DEBOUNCE_CYCLES(4),
    .ENTRY_WINDOW   (100),
    .CODE_PRESSES   (3),
    .LOCKOUT_CYCLES (50),
    .MAX_FAILS      (3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ignition         (ignition),
    .brake            (brake),
    .hidden_switch_raw(hidden_switch_raw),
    .pump_grant       (pump_grant),
    .entry_active     (entry_active),
    .locked_out       (locked_out),
    .alarm            (alarm)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    ignition = 1'b0;
    brake = 1'b0;
    hidden_switch_raw = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic hold(input logic v, input int n);
    hidden_switch_raw = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic key_off(input int n);
    ignition = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_plan();
    n_press = 0;
    ign_drop_at = -1;
  endtask

  task automatic add_press(input int at, input int kind, input logic brk);
    press_at[n_press]    = at;
    press_kind[n_press]  = kind;
    press_brake[n_press] = brk;
    n_press++;
  endtask

  // Runs one entry window: drives the planned presses while counting entry_active cycles,
  // then pops the expected outcome and compares it with the first post-window state.
  task automatic run_window(input string name, input logic [3:0] exp);
    int t;
    int cnt;
    int guard;
    logic [3:0] got;
    logic [3:0] want;
    exp_q.push_back(exp);
    ignition = 1'b1;
    fork
      begin
        t = 0;
        for (int i = 0; i < n_press; i++) begin
          while (t < press_at[i]) begin
            @(negedge clk);
            t++;
          end
          brake = press_brake[i];
          if (press_kind[i] == KIND_CLEAN) begin
            hold(1'b1, 10);
            t += 10;
          end else if (press_kind[i] == KIND_BOUNCY) begin
            hold(1'b1, 3); hold(1'b0, 1); hold(1'b1, 10); hold(1'b0, 3); hold(1'b1, 1);
            t += 18;
          end else begin
            hold(1'b1, 2);
            t += 2;
          end
          hidden_switch_raw = 1'b0;
        end
        if (ign_drop_at >= 0) begin
          while (t < ign_drop_at) begin
            @(negedge clk);
            t++;
          end
          ignition = 1'b0;
        end
      end
      begin
        cnt = 0;
        guard = 0;
        while (guard < 400) begin
          if (entry_active) cnt++;
          else if (cnt > 0) break;
          @(negedge clk);
          guard++;
        end
        checks++;
        if (guard >= 400) begin
          $display("FAIL %s window_timeout: waited %0d cycles, required window end", name, guard);
          errors++;
        end
        checks++;
        if (cnt !== 100) begin
          $display("FAIL %s entry_len: got %0d cycles, want 100", name, cnt);
          errors++;
        end
        got = {pump_grant, entry_active, locked_out, alarm};
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s outcome: got %b, expected queue empty", name, got);
          errors++;
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            $display("FAIL %s outcome: got %b want %b", name, got, want);
            errors++;
          end
        end
      end
    join
  endtask

  task automatic wait_lockout(input string name);
    int cnt;
    int guard;
    cnt = 0;
    guard = 0;
    while (guard < 200) begin
      if (locked_out) cnt++;
      else break;
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cnt !== 50) begin
      $display("FAIL %s lockout_len: got %0d cycles, want 50", name, cnt);
      errors++;
    end
    checks++;
    if (entry_active !== 1'b1) begin
      $display("FAIL %s reentry: entry_active got %b want 1", name, entry_active);
      errors++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    ignition = 1'b1;
    brake = 1'b0;
    hidden_switch_raw = 1'b0;
    @(negedge clk);
    checks++;
    if ({pump_grant, entry_active, locked_out, alarm} !== 4'b0000) begin
      $display("FAIL reset_outputs: got %b want 0000", {pump_grant, entry_active, locked_out, alarm});
      errors++;
    end
    ignition = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pump_grant, entry_active, locked_out, alarm} !== 4'b0000) begin
      $display("FAIL idle_key_off: got %b want 0000", {pump_grant, entry_active, locked_out, alarm});
      errors++;
    end
  endtask

  task automatic test_correct_code();
    int k;
    clear_plan();
    add_press(0, KIND_CLEAN, 1'b1);
    add_press(20, KIND_CLEAN, 1'b1);
    add_press(40, KIND_CLEAN, 1'b1);
    run_window("correct", O_GRANT);
    repeat (20) @(negedge clk);
    checks++;
    if (pump_grant !== 1'b1) begin
      $display("FAIL grant_held: pump_grant got %b want 1", pump_grant);
      errors++;
    end
    ignition = 1'b0;
    k = 0;
    while (k < 2) begin
      @(negedge clk);
      k++;
      if (!pump_grant) break;
    end
    checks++;
    if ({pump_grant, entry_active} !== 2'b00) begin
      $display("FAIL grant_drop: {grant,entry} got %b want 00 within 2 cycles", {pump_grant, entry_active});
      errors++;
    end
    key_off(20);
  endtask

  task automatic test_bounce();
    clear_plan();
    add_press(0, KIND_BOUNCY, 1'b1);
    add_press(28, KIND_BOUNCY, 1'b1);
    add_press(56, KIND_BOUNCY, 1'b1);
    add_press(84, KIND_GLITCH, 1'b1);
    run_window("bounce", O_GRANT);
    key_off(20);
  endtask

  task automatic test_wrong_count();
    clear_plan();
    add_press(0, KIND_CLEAN, 1'b1);
    add_press(20, KIND_CLEAN, 1'b1);
    run_window("two_presses", O_LOCK);
    wait_lockout("two_presses");
    clear_plan();
    for (int i = 0; i < 4; i++) add_press(i * 20, KIND_CLEAN, 1'b1);
    run_window("four_presses", O_LOCK);
    wait_lockout("four_presses");
    clear_plan();
    for (int i = 0; i < 3; i++) add_press(i * 20, KIND_CLEAN, 1'b1);
    run_window("grant_clears_fails", O_GRANT);
    key_off(20);
    clear_plan();
    add_press(0, KIND_CLEAN, 1'b1);
    add_press(20, KIND_CLEAN, 1'b0);
    add_press(40, KIND_CLEAN, 1'b1);
    run_window("brake_off_press", O_LOCK);
    do_reset();
  endtask

  task automatic test_alarm_key_cycle();
    do_reset();
    clear_plan();
    run_window("alarm_fail1", O_LOCK);
    key_off(20);
    checks++;
    if ({entry_active, locked_out, alarm} !== 3'b000) begin
      $display("FAIL key_off_idle: {entry,lock,alarm} got %b want 000", {entry_active, locked_out, alarm});
      errors++;
    end
    clear_plan();
    add_press(0, KIND_CLEAN, 1'b1);
    run_window("alarm_fail2", O_LOCK);
    wait_lockout("alarm_fail2");
    clear_plan();
    add_press(0, KIND_CLEAN, 1'b1);
    add_press(20, KIND_CLEAN, 1'b1);
    run_window("alarm_fail3", O_ALARM);
    key_off(10);
    ignition = 1'b1;
    brake = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hold(1'b1, 10);
      hold(1'b0, 10);
    end
    repeat (100) @(negedge clk);
    checks++;
    if ({pump_grant, entry_active, alarm} !== 3'b001) begin
      $display("FAIL alarm_sticky: {grant,entry,alarm} got %b want 001", {pump_grant, entry_active, alarm});
      errors++;
    end
    do_reset();
    checks++;
    if (alarm !== 1'b0) begin
      $display("FAIL alarm_rst: alarm got %b want 0", alarm);
      errors++;
    end
  endtask

  task automatic test_reset_mid_entry();
    ignition = 1'b1;
    brake = 1'b1;
    for (int i = 0; i < 2; i++) begin
      hold(1'b1, 10);
      hold(1'b0, 10);
    end
    checks++;
    if (entry_active !== 1'b1) begin
      $display("FAIL mid_entry: entry_active got %b want 1", entry_active);
      errors++;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({pump_grant, entry_active, locked_out, alarm} !== 4'b0000) begin
      $display("FAIL rst_mid_entry: got %b want 0000", {pump_grant, entry_active, locked_out, alarm});
      errors++;
    end
    ignition = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    clear_plan();
    for (int i = 0; i < 3; i++) add_press(i * 20, KIND_CLEAN, 1'b1);
    run_window("fresh_window", O_GRANT);
    key_off(20);
  endtask

  task automatic test_boundaries();
    do_reset();
    // Raw rise at offset 93 lands its pulse one cycle before the close cycle.
    clear_plan();
    add_press(0, KIND_CLEAN, 1'b1);
    add_press(20, KIND_CLEAN, 1'b1);
    add_press(93, KIND_CLEAN, 1'b1);
    run_window("press_before_close", O_GRANT);
    key_off(20);
    clear_plan();
    add_press(0, KIND_CLEAN, 1'b1);
    add_press(20, KIND_CLEAN, 1'b1);
    add_press(94, KIND_CLEAN, 1'b1);
    run_window("press_on_close", O_LOCK);
    do_reset();
    clear_plan();
    ign_drop_at = 100;
    run_window("ign_drop_on_close", O_IDLE);
    key_off(5);
    clear_plan();
    run_window("after_drop_fail1", O_LOCK);
    key_off(5);
    clear_plan();
    run_window("after_drop_fail2", O_LOCK);
    do_reset();
  endtask

  initial begin
    rst = 1'b1;
    ignition = 1'b0;
    brake = 1'b0;
    hidden_switch_raw = 1'b0;
    clear_plan();
    @(negedge clk);
    test_reset();
    test_correct_code();
    test_bounce();
    test_wrong_count();
    test_alarm_key_cycle();
    test_reset_mid_entry();
    test_boundaries();
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d outcomes left, want 0", exp_q.size());
      errors++;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
